// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache/main-memory arbiter.
package cache_mem_pkg;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic OWNER_ICACHE = 1'b0;
  localparam logic OWNER_DCACHE = 1'b1;
  localparam logic OP_RD        = 1'b0;
  localparam logic OP_WR        = 1'b1;

  function automatic int line_words(input int line_addr_len);
    return 1 << line_addr_len;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker: on a tie the requester that was not served last wins.
module rr_arb2
  import cache_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);

  always_comb begin
    gnt = OWNER_ICACHE;
    if (req == 2'b11) gnt = ~last;
    else if (req[1])  gnt = OWNER_DCACHE;
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one word-wide memory port between ICache (port 0) and DCache (port 1),
// moving whole lines as word bursts: writeback before refill, round-robin between caches.
module cache_mem_arbiter
  import cache_mem_pkg::*;
#(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_WIDTH    = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  c0_rd_req,
  input  logic                                  c0_wr_req,
  input  logic [ADDR_WIDTH-1:0]                 c0_addr,
  input  logic [32*(2**LINE_ADDR_LEN)-1:0]      c0_wr_line,
  output logic [32*(2**LINE_ADDR_LEN)-1:0]      c0_rd_line,
  output logic                                  c0_done,
  input  logic                                  c1_rd_req,
  input  logic                                  c1_wr_req,
  input  logic [ADDR_WIDTH-1:0]                 c1_addr,
  input  logic [32*(2**LINE_ADDR_LEN)-1:0]      c1_wr_line,
  output logic [32*(2**LINE_ADDR_LEN)-1:0]      c1_rd_line,
  output logic                                  c1_done,
  output logic                                  mem_req,
  output logic                                  mem_we,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [31:0]                           mem_wdata,
  input  logic [31:0]                           mem_rdata,
  input  logic                                  mem_ack,
  output logic                                  busy,
  output logic                                  owner
);

  localparam int LINE_BITS = 32 * line_words(LINE_ADDR_LEN);
  localparam int TAG_W     = ADDR_WIDTH - LINE_ADDR_LEN - 2;

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_owner;
  logic                     r_last_owner;
  logic                     r_op;
  logic [TAG_W-1:0]         r_line;
  logic [LINE_BITS-1:0]     r_wline;
  logic [LINE_BITS-1:0]     r_buf;
  logic [LINE_ADDR_LEN-1:0] r_cnt;

  logic [1:0]               w_req;
  logic                     w_gnt;
  logic                     w_op;
  logic [ADDR_WIDTH-1:0]    w_addr;
  logic [LINE_BITS-1:0]     w_wline;
  logic                     w_last;
  logic                     w_unused;

  assign w_req    = {c1_rd_req | c1_wr_req, c0_rd_req | c0_wr_req};
  assign w_op     = (w_gnt ? c1_wr_req : c0_wr_req) ? OP_WR : OP_RD;
  assign w_addr   = w_gnt ? c1_addr : c0_addr;
  assign w_wline  = w_gnt ? c1_wr_line : c0_wr_line;
  assign w_last   = (r_cnt == '1);
  assign w_unused = ^{c0_addr[LINE_ADDR_LEN+1:0], c1_addr[LINE_ADDR_LEN+1:0]};

  rr_arb2 u_arb (
    .req  (w_req),
    .last (r_last_owner),
    .gnt  (w_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Memory-side outputs decode straight from state so an async reset drops mem_req at once.
  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    c0_done   = 1'b0;
    c1_done   = 1'b0;
    case (r_state)
      IDLE: if (|w_req) w_next = XFER;
      XFER: begin
        mem_req   = 1'b1;
        mem_we    = r_op;
        mem_addr  = {r_line, r_cnt, 2'b00};
        mem_wdata = r_wline[{r_cnt, 5'b0} +: 32];
        if (mem_ack && w_last) w_next = DONE;
      end
      DONE: begin
        c0_done = (r_owner == OWNER_ICACHE);
        c1_done = (r_owner == OWNER_DCACHE);
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= OWNER_DCACHE;
      r_last_owner <= OWNER_DCACHE;
      r_op         <= OP_RD;
      r_line       <= '0;
      r_wline      <= '0;
      r_buf        <= '0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: if (|w_req) begin
          r_owner <= w_gnt;
          r_op    <= w_op;
          r_line  <= w_addr[ADDR_WIDTH-1 -: TAG_W];
          r_wline <= w_wline;
          r_cnt   <= '0;
        end
        XFER: if (mem_ack) begin
          if (r_op == OP_RD) r_buf[{r_cnt, 5'b0} +: 32] <= mem_rdata;
          r_cnt <= r_cnt + 1'b1;
        end
        DONE: r_last_owner <= r_owner;
        default: ;
      endcase
    end
  end

  assign c0_rd_line = r_buf;
  assign c1_rd_line = r_buf;
  assign busy       = (r_state != IDLE);
  assign owner      = r_owner;

endmodule
